// File: rtl/count_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// count_seq_ctrl_if
//
// Request/status bundle between a requester (software shim or controlling FSM)
// and the count_seq_ctrl interval timer.
//
// Parameters:
//   WIDTH   width of load_val and count
//   PCNT_W  width of the saturating completed-period counter
//
// Signals:
//   start     requester -> timer  begin (from IDLE) or resume (from HOLD)
//   stop      requester -> timer  pause (from RUN) or abort (from HOLD)
//   mode      requester -> timer  0 = one-shot, 1 = periodic
//   load_val  requester -> timer  terminal count value
//   count     timer -> requester  current count, registered
//   busy      timer -> requester  high while running or held
//   done      timer -> requester  one-cycle pulse per terminal event
//   periods   timer -> requester  completed periods since last start
//
// Modports:
//   master  the requester side
//   slave   the timer side
// -----------------------------------------------------------------------------
interface count_seq_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
);
    logic              start;
    logic              stop;
    logic              mode;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              done;
    logic [PCNT_W-1:0] periods;

    modport master (
        output start,
        output stop,
        output mode,
        output load_val,
        input  count,
        input  busy,
        input  done,
        input  periods
    );

    modport slave (
        input  start,
        input  stop,
        input  mode,
        input  load_val,
        output count,
        output busy,
        output done,
        output periods
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// -----------------------------------------------------------------------------
// count_seq_ctrl
//
// Start/stop programmable interval timer built around a WIDTH-bit up counter.
// Owns the count register and a three-state IDLE/RUN/HOLD sequencer, and
// emits a one-cycle done pulse each time the count reaches the terminal value
// captured at start.
//
// Parameters:
//   WIDTH     width of count and load_val
//   PCNT_W    width of the saturating completed-period counter
//   PRESCALE  clk cycles per count advance (1..255), only meaningful when the
//             prescaler is compiled in
//
// Build option:
//   COUNT_PRESCALE_EN  when defined, an 8-bit prescaler makes the counter
//                      advance only once every PRESCALE clk cycles while
//                      running. When undefined the counter advances on every
//                      RUN edge and no prescaler logic exists.
//
// Ports:
//   clk   rising-edge clock, the only clock
//   rst   synchronous active-high reset; clears every register, state -> IDLE
//   bus   count_seq_ctrl_if.slave: start/stop/mode/load_val in,
//         count/busy/done/periods out (all outputs registered)
// -----------------------------------------------------------------------------
module count_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PCNT_W   = 8,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           rst,
    count_seq_ctrl_if.slave bus
);

    // Reject an unusable prescale ratio at elaboration time.
    generate
        if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
            $error("count_seq_ctrl: PRESCALE must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_reg,   state_next;
    logic [WIDTH-1:0]   count_reg,   count_next;
    logic [WIDTH-1:0]   term_reg,    term_next;
    logic               mode_reg,    mode_next;
    logic               busy_reg,    busy_next;
    logic               done_reg,    done_next;
    logic [PCNT_W-1:0]  periods_reg, periods_next;

    // Advance qualifier: high on edges where a running counter may move.
    logic tick;

`ifdef COUNT_PRESCALE_EN
    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    logic [7:0] presc_reg, presc_next;

    // The tick lands on the PRESCALE-th RUN edge after a clear, so a start at
    // edge E0 first advances the count at E0+PRESCALE.
    assign tick = (presc_reg == PRESC_LAST);
`else
    assign tick = 1'b1;
`endif

    // Terminal detect built bitwise so each bit's compare is independent.
    logic [WIDTH-1:0] eq_bits;
    logic             at_term;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_term_cmp
            assign eq_bits[gi] = ~(count_reg[gi] ^ term_reg[gi]);
        end
    endgenerate

    assign at_term = &eq_bits;

    // periods stops incrementing once it is all-ones.
    logic periods_full;
    assign periods_full = &periods_reg;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            term_reg    <= '0;
            mode_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            periods_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            term_reg    <= term_next;
            mode_reg    <= mode_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            periods_reg <= periods_next;
        end
    end

`ifdef COUNT_PRESCALE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= 8'd0;
        end else begin
            presc_reg <= presc_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        term_next    = term_reg;
        mode_next    = mode_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        periods_next = periods_reg;
`ifdef COUNT_PRESCALE_EN
        presc_next   = presc_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                // start and stop together is not a valid begin request.
                if (bus.start && !bus.stop) begin
                    term_next    = bus.load_val;
                    mode_next    = bus.mode;
                    count_next   = '0;
                    periods_next = '0;
                    busy_next    = 1'b1;
                    state_next   = ST_RUN;
`ifdef COUNT_PRESCALE_EN
                    presc_next   = 8'd0;
`endif
                end
            end

            ST_RUN: begin
                // stop wins over start and over a coincident terminal event;
                // the prescaler is left untouched so a resume keeps its phase.
                if (bus.stop) begin
                    state_next = ST_HOLD;
                end else begin
`ifdef COUNT_PRESCALE_EN
                    presc_next = tick ? 8'd0 : (presc_reg + 8'd1);
`endif
                    if (tick) begin
                        if (at_term) begin
                            done_next = 1'b1;
                            if (!periods_full) begin
                                periods_next = periods_reg + 1'b1;
                            end
                            if (mode_reg) begin
                                count_next = '0;
                            end else begin
                                // One-shot leaves count parked on term.
                                busy_next  = 1'b0;
                                state_next = ST_IDLE;
                            end
                        end else begin
                            // term is reached before wrap, so no overflow.
                            count_next = count_reg + 1'b1;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (bus.stop) begin
                    // Abort: no done pulse, periods keeps its value.
                    count_next = '0;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else if (bus.start) begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.count   = count_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.periods = periods_reg;

endmodule

// File: tb/tb_count_seq_ctrl.sv
module tb_count_seq_ctrl;

    localparam int WIDTH  = 4;
    localparam int PCNT_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    count_seq_ctrl_if #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) bus_if ();

    count_seq_ctrl #(
        .WIDTH   (WIDTH),
        .PCNT_W  (PCNT_W),
        .PRESCALE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int check_cnt = 0;
    int fail_cnt  = 0;

    // Expected vectors, hand-derived from the timer behaviour.
    // One-shot, load_val=3, rows are E0..E5.
    int os_c [6] = '{0, 1, 2, 3, 3, 3};
    int os_b [6] = '{1, 1, 1, 1, 0, 0};
    int os_d [6] = '{0, 0, 0, 0, 1, 0};
    // Periodic, load_val=2, rows are E0..E9.
    int pe_c [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    int pe_d [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    // Prescaled one-shot, PRESCALE=4, load_val=1, rows are E0..E9.
    int ps_c [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int ps_b [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int ps_d [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic check_out(input string tag, input int c, input int b, input int d);
        check({tag, ".count"}, 32'(bus_if.count), 32'(c));
        check({tag, ".busy"},  32'(bus_if.busy),  32'(b));
        check({tag, ".done"},  32'(bus_if.done),  32'(d));
    endtask

    task automatic drive(input int s, input int p, input int m, input int lv);
        bus_if.start    = (s != 0);
        bus_if.stop     = (p != 0);
        bus_if.mode     = (m != 0);
        bus_if.load_val = 4'(lv);
    endtask

    // Advance one edge and settle; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        step();
        step();
        check_out("reset", 0, 0, 0);
        check("reset.periods", 32'(bus_if.periods), 0);
        rst = 1'b0;

`ifdef COUNT_PRESCALE_EN
        // Prescaled one-shot: first advance at E4, terminal event at E8.
        drive(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) drive(0, 0, 0, 0);
            check_out($sformatf("presc.E%0d", i), ps_c[i], ps_b[i], ps_d[i]);
        end
`else
        // One-shot, load_val=3; mode/load_val changed mid-run must be ignored.
        drive(1, 0, 0, 3);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) drive(0, 0, 1, 9);
            check_out($sformatf("oneshot.E%0d", i), os_c[i], os_b[i], os_d[i]);
        end
        check("oneshot.periods", 32'(bus_if.periods), 1);

        // Periodic, load_val=2, ten edges.
        drive(1, 0, 1, 2);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) drive(0, 0, 0, 0);
            check_out($sformatf("periodic.E%0d", i), pe_c[i], 1, pe_d[i]);
        end
        check("periodic.periods", 32'(bus_if.periods), 3);
        drive(0, 1, 0, 0);
        step();
        check_out("periodic.pause", 0, 1, 0);
        step();
        check_out("periodic.abort", 0, 0, 0);
        drive(0, 0, 0, 0);

        // Pause at 4, hold five cycles, resume to terminal 7.
        drive(1, 0, 0, 7);
        step();
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_out($sformatf("pause.run%0d", i), i, 1, 0);
        end
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0);
        check_out("pause.enter", 4, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("pause.hold%0d", i), 4, 1, 0);
        end
        drive(1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0);
        check_out("pause.resume", 4, 1, 0);
        for (int i = 5; i <= 7; i++) begin
            step();
            check_out($sformatf("pause.run%0d", i), i, 1, 0);
        end
        step();
        check_out("pause.term", 7, 0, 1);
        check("pause.periods", 32'(bus_if.periods), 1);

        // Second stop while held aborts without a done pulse.
        drive(1, 0, 0, 7);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        check_out("abort.at2", 2, 1, 0);
        drive(0, 1, 0, 0);
        step();
        check_out("abort.hold", 2, 1, 0);
        step();
        check_out("abort.idle", 0, 0, 0);
        drive(0, 0, 0, 0);
        step();
        check_out("abort.after", 0, 0, 0);

        // Reset mid-RUN, then a fresh start.
        drive(1, 0, 1, 5);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        step();
        check_out("rstrun.at3", 3, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("rstrun.cleared", 0, 0, 0);
        check("rstrun.periods", 32'(bus_if.periods), 0);
        drive(1, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
        check_out("rstrun.E0", 0, 1, 0);
        step();
        check_out("rstrun.E1", 1, 1, 0);
        step();
        check_out("rstrun.E2", 1, 0, 1);
        step();
        check_out("rstrun.E3", 1, 0, 0);

        // start=stop=1 in RUN at count==term: HOLD, no done.
        drive(1, 0, 0, 2);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        check_out("simul.at_term", 2, 1, 0);
        drive(1, 1, 0, 0);
        step();
        check_out("simul.run", 2, 1, 0);
        drive(0, 1, 0, 0);
        step();
        check_out("simul.abort", 0, 0, 0);
        // start=stop=1 in IDLE: stays IDLE.
        drive(1, 1, 0, 5);
        step();
        check_out("simul.idle", 0, 0, 0);
        drive(0, 0, 0, 0);
        step();
        check_out("simul.idle2", 0, 0, 0);

        // Full range one-shot, load_val=15.
        drive(1, 0, 0, 15);
        step();
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) step();
        check_out("full.at15", 15, 1, 0);
        step();
        check_out("full.term", 15, 0, 1);

        // load_val=0 periodic: done every cycle, periods saturates at 255.
        drive(1, 0, 1, 0);
        step();
        drive(0, 0, 0, 0);
        check_out("zero.E0", 0, 1, 0);
        for (int k = 1; k <= 260; k++) begin
            step();
            if (k <= 3 || k >= 253) begin
                check_out($sformatf("zero.E%0d", k), 0, 1, 1);
                check($sformatf("zero.E%0d.periods", k), 32'(bus_if.periods),
                      32'((k > 255) ? 255 : k));
            end
        end
        drive(0, 1, 0, 0);
        step();
        step();
        drive(0, 0, 0, 0);
        check_out("zero.abort", 0, 0, 0);
        check("zero.periods_kept", 32'(bus_if.periods), 255);
        drive(1, 0, 0, 5);
        step();
        drive(0, 0, 0, 0);
        check("zero.restart_periods", 32'(bus_if.periods), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
